// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator: 50 Hz frame, pulse width derived from an 8-bit angle
// by an iterative shift-add multiplier. The new width is committed only at the frame wrap.
module servo_pwm_gen #(
  parameter int FRAME_CYC   = 1000000,
  parameter int MIN_CYC     = 25000,
  parameter int CYC_PER_DEG = 555,
  parameter int MAX_ANGLE   = 180,
  parameter int LOAD_AT     = FRAME_CYC - 16
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [7:0]  iAngle,
  input  logic        iEnable,
  output logic        oPwm,
  output logic        oFrame,
  output logic [16:0] oWidth,
  output logic        oClamp
);

  localparam logic [19:0] LAST_CNT = 20'(FRAME_CYC - 1);
  localparam logic [19:0] LOAD_CNT = 20'(LOAD_AT);
  localparam logic [16:0] MIN_W    = 17'(MIN_CYC);
  localparam logic [16:0] DEG_W    = 17'(CYC_PER_DEG);
  localparam logic [16:0] RESET_W  = 17'(MIN_CYC + 60 * CYC_PER_DEG);
  localparam logic [7:0]  MAX_A    = 8'(MAX_ANGLE);

  typedef enum logic [1:0] {IDLE, MUL, DONE} mulState_t;

  mulState_t   state, nextState;
  logic [19:0] frameCnt, nextCnt;
  logic        wrap, sampleEvt, nextEn, enLatched;
  logic [16:0] nextWidth, shadowWidth, acc;
  logic [7:0]  angleReg;
  logic [2:0]  bitIdx;

  always_comb begin
    wrap      = (frameCnt == LAST_CNT);
    sampleEvt = (frameCnt == LOAD_CNT);
    nextCnt   = wrap ? '0 : frameCnt + 20'd1;
    nextWidth = wrap ? shadowWidth : oWidth;
    nextEn    = wrap ? iEnable : enLatched;
  end

  // Outputs are computed from next-cycle values so they line up with the counter.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      frameCnt  <= '0;
      oFrame    <= 1'b0;
      oPwm      <= 1'b0;
      oWidth    <= RESET_W;
      enLatched <= 1'b0;
    end else begin
      frameCnt  <= nextCnt;
      oFrame    <= wrap;
      oWidth    <= nextWidth;
      enLatched <= nextEn;
      oPwm      <= nextEn && (nextCnt < {3'b000, nextWidth});
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      angleReg <= '0;
      oClamp   <= 1'b0;
    end else begin
      oClamp <= sampleEvt && (iAngle > MAX_A);
      if (sampleEvt)
        angleReg <= (iAngle > MAX_A) ? MAX_A : iAngle;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (sampleEvt) nextState = MUL;
      MUL:     if (bitIdx == 3'd7) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // One multiplier bit per MUL cycle, LSB first.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state       <= IDLE;
      acc         <= '0;
      bitIdx      <= '0;
      shadowWidth <= RESET_W;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (sampleEvt) begin
            acc    <= MIN_W;
            bitIdx <= '0;
          end
        end
        MUL: begin
          if (angleReg[bitIdx])
            acc <= acc + (DEG_W << bitIdx);
          bitIdx <= bitIdx + 3'd1;
        end
        DONE:    shadowWidth <= acc;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
- Downstream of the angle-command stage. Consumes its 8-bit orientation angle (0..180 degrees) and drives the hobby-servo control line: a 50 Hz frame carrying a 0.5–2.5 ms high pulse.
- The angle is sampled once per frame and converted to a pulse width by an iterative shift-add multiplier.
- The new width is committed only at the frame boundary, so the pulse never glitches mid-frame.

Parameters:
- FRAME_CYC, 1000000: clock cycles per PWM frame (20 ms at 50 MHz).
- MIN_CYC, 25000: pulse width for 0 degrees (0.5 ms).
- CYC_PER_DEG, 555: added cycles per degree; 180 deg gives 124900 cycles (2.498 ms).
- MAX_ANGLE, 180: clamp ceiling for the input angle.
- LOAD_AT, FRAME_CYC-16: frame-counter value at which the angle is sampled.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  asynchronous active-high reset.
- iAngle  in  8  commanded angle in degrees, from the angle-command stage.
- iEnable  in  1  drive enable; sampled at frame boundary.
- oPwm  out  1  servo control pulse.
- oFrame  out  1  one-cycle strobe at the start of each frame (counter == 0).
- oWidth  out  17  pulse width in cycles currently being driven.
- oClamp  out  1  one-cycle strobe when a sampled angle exceeded MAX_ANGLE.

Behaviour:
Reset (iRst=1, async):
- Frame counter = 0; oPwm = 0; oFrame = 0; oClamp = 0.
- oWidth = MIN_CYC + 60*CYC_PER_DEG = 58300, matching the 60-degree default of the angle stage.
- Latched enable = 0, so the first frame after reset is always low.
- Multiplier FSM = IDLE; shadow width = 58300.

Frame counter:
- Free-running 20-bit counter, 0..FRAME_CYC-1, wraps to 0.
- oFrame = 1, registered, exactly in the cycle the counter equals 0.

Sampling:
- When counter == LOAD_AT, register a = min(iAngle, MAX_ANGLE).
- oClamp pulses 1 in the following cycle iff iAngle > MAX_ANGLE.

Multiplier FSM (IDLE -> MUL -> DONE -> IDLE):
- IDLE: on the sample event, go to MUL with acc = MIN_CYC and bit index = 0.
- MUL: 8 cycles, one multiplier bit per cycle, LSB first. If a[i]=1, acc += CYC_PER_DEG << i. Accumulator is 17 bits; the maximum result 124900 cannot overflow after clamping.
- DONE: one cycle. shadow width <= acc, then return to IDLE.
- Total 10 cycles from sample to shadow valid, well before the wrap (16 cycles of margin).

Commit:
- At wrap (counter FRAME_CYC-1 -> 0): oWidth <= shadow width; latched enable <= iEnable.
- The new width and enable take effect starting at counter == 0 of the new frame.

Output:
- oPwm registered = latched enable AND (counter < oWidth).
- The high pulse is exactly oWidth cycles, starting at counter 0. It is 0 for the whole frame when disabled.

Boundary conditions:
- iAngle changes outside the LOAD_AT cycle have no effect until the next frame.
- Disable mid-frame does not truncate the current pulse; it takes effect next frame.
- Reset mid-multiply aborts the FSM; shadow and oWidth return to 58300.
- iAngle = 0 gives width MIN_CYC exactly. Angles do not need to be multiples of 5; any 0..180 value is exact.

Test Plan:
- Reset, iEnable=1, iAngle=60: frame 1 oPwm low throughout. Frame 2 oPwm high 58300 cycles from oFrame, low for the remaining 941700; oWidth=58300.
- iAngle=180 before LOAD_AT: next frame oWidth=124900 and pulse 124900 cycles. iAngle=0: next frame oWidth=25000.
- iAngle=200 held: oClamp strobes once per frame one cycle after LOAD_AT; oWidth=124900.
- iAngle toggled 30/150 every 1000 cycles mid-frame, 150 at LOAD_AT: current pulse width unchanged; next frame width=25000+150*555=108250.
- iEnable dropped at counter 10000 during a 58300 pulse: current pulse completes full width; next frame oPwm stays 0 and oFrame still strobes.
- iRst asserted 3 cycles after LOAD_AT, released 5 cycles later: oPwm=0 immediately. oWidth=58300, counter restarts at 0, and the first frame after release is low.
